// File: rtl/ram_banked_dp.sv
// ram_banked_dp
// Banked, synchronous dual-port RAM with one write port and one read port.
// Storage is split into 2^BANK_BITS banks selected by the upper address
// bits. The block clears every row to zero after reset before it accepts
// requests. It supports per-byte write enables and a defined same-address
// read-during-write policy with a collision flag. The read data passes
// through a registered bank mux, optionally followed by one more output
// stage.
//
// Ports
//   clock        single clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   write_en     write request (ignored until ready)
//   wr_addr      write word address; top BANK_BITS bits pick the bank
//   wr_be        byte enables; bit i covers top_data_in[8i+7:8i]
//   top_data_in  write data
//   read_en      read request (ignored until ready)
//   rd_addr      read word address
//   top_data_out read data; holds its value between reads
//   rd_valid     one-cycle pulse marking top_data_out as new
//   collision    pulses with rd_valid when the read met a same-address write
//   ready        high once the clear sequence has finished
module ram_banked_dp #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_BITS  = 2,
  parameter int RDW_MODE   = 1,
  parameter int OUT_REG    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   top_data_in,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   top_data_out,
  output logic                    rd_valid,
  output logic                    collision,
  output logic                    ready
);

  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int NBANKS   = 1 << BANK_BITS;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ROW_BITS-1:0]   r_cnt;
  logic [ROW_BITS-1:0]   w_nextCnt;
  logic                  w_clearEn;
  logic                  w_accept;

  logic [BANK_BITS-1:0]  w_wrBank;
  logic [BANK_BITS-1:0]  w_rdBank;
  logic [ROW_BITS-1:0]   w_wrRow;
  logic [ROW_BITS-1:0]   w_rdRow;
  logic                  w_wrAcc;
  logic                  w_rdAcc;
  logic                  w_rdCollide;

  logic [DATA_WIDTH-1:0] w_bankData [NBANKS];
  logic [DATA_WIDTH-1:0] w_selData;
  logic [DATA_WIDTH-1:0] w_merged;

  logic                  r_v1;
  logic                  r_coll1;
  logic [BANK_BITS-1:0]  r_rdBank;
  logic [DATA_WIDTH-1:0] r_bypData;
  logic [NBYTES-1:0]     r_bypBe;

  logic                  r_v2;
  logic                  r_c2;
  logic [DATA_WIDTH-1:0] r_d2;

  // State register and clear counter. Reset restarts the clear from row 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // INIT walks every row once, clearing all banks in parallel. After the
  // last row it moves to RUN, and requests are accepted from then on.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_clearEn   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      INIT: begin
        w_clearEn = ~reset;
        w_nextCnt = r_cnt + ROW_BITS'(1);
        if (r_cnt == {ROW_BITS{1'b1}}) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_accept = ~reset;
      end
      default: begin
        w_nextState = INIT;
      end
    endcase
  end

  assign w_wrBank    = wr_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_rdBank    = rd_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_wrRow     = wr_addr[ROW_BITS-1:0];
  assign w_rdRow     = rd_addr[ROW_BITS-1:0];
  assign w_wrAcc     = w_accept & write_en;
  assign w_rdAcc     = w_accept & read_en;
  assign w_rdCollide = w_rdAcc & w_wrAcc & (rd_addr == wr_addr);

  // One storage array per bank. Each bank owns its own read register, so a
  // bank only ever presents its data to the output mux. Both the write and
  // the fetch use the memory value from before the edge, so a same-address
  // fetch naturally sees the pre-write word.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [ROWS];
    logic [DATA_WIDTH-1:0] r_rdData;

    always_ff @(posedge clock) begin
      if (w_clearEn) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wrAcc && (w_wrBank == BANK_BITS'(b))) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (wr_be[i]) begin
            r_mem[w_wrRow][8*i +: 8] <= top_data_in[8*i +: 8];
          end
        end
      end
      if (w_rdAcc && (w_rdBank == BANK_BITS'(b))) begin
        r_rdData <= r_mem[w_rdRow];
      end
    end

    assign w_bankData[b] = r_rdData;
  end

  // Fetch-stage control. The valid and collision bits are flushed by reset
  // so that an in-flight read never surfaces.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_coll1 <= 1'b0;
    end else begin
      r_v1    <= w_rdAcc;
      r_coll1 <= w_rdCollide;
    end
  end

  // The bank index and the write data/enables travel with the fetch. The
  // mux then selects with the registered index, and the write-first bypass
  // can merge bytes one cycle later.
  always_ff @(posedge clock) begin
    if (w_rdAcc) begin
      r_rdBank  <= w_rdBank;
      r_bypData <= top_data_in;
      r_bypBe   <= wr_be;
    end
  end

  // Bank select plus the per-byte write-first merge on a collision.
  always_comb begin
    w_selData = w_bankData[r_rdBank];
    w_merged  = w_selData;
    if ((RDW_MODE != 0) && r_coll1) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (r_bypBe[i]) begin
          w_merged[8*i +: 8] = r_bypData[8*i +: 8];
        end
      end
    end
  end

  // Registered mux output. Data only moves when a read completes, so the
  // last result is held in between.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v2 <= 1'b0;
      r_c2 <= 1'b0;
      r_d2 <= '0;
    end else begin
      r_v2 <= r_v1;
      r_c2 <= r_v1 & r_coll1;
      if (r_v1) begin
        r_d2 <= w_merged;
      end
    end
  end

  if (OUT_REG != 0) begin : g_outReg
    logic                  r_v3;
    logic                  r_c3;
    logic [DATA_WIDTH-1:0] r_d3;

    // Extra output pipeline stage; it holds its data the same way.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_v3 <= 1'b0;
        r_c3 <= 1'b0;
        r_d3 <= '0;
      end else begin
        r_v3 <= r_v2;
        r_c3 <= r_c2;
        if (r_v2) begin
          r_d3 <= r_d2;
        end
      end
    end

    assign top_data_out = r_d3;
    assign rd_valid     = r_v3;
    assign collision    = r_c3;
  end else begin : g_noOutReg
    assign top_data_out = r_d2;
    assign rd_valid     = r_v2;
    assign collision    = r_c2;
  end

  assign ready = (r_state == RUN);

endmodule

// File: tb/tb_ram_banked_dp.sv
// tb_ram_banked_dp
// Drives two instances of ram_banked_dp with the same inputs:
//   dut0: RDW_MODE=1 (write-first), OUT_REG=0
//   dut1: RDW_MODE=0 (old data),    OUT_REG=1
// A behavioural model keeps a flat word array and the read results in
// flight, and predicts both instances' outputs after every clock edge.
module tb_ram_banked_dp;

  localparam int DW    = 128;
  localparam int AW    = 12;
  localparam int BB    = 2;
  localparam int NB    = DW / 8;
  localparam int ROWS  = 1 << (AW - BB);
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          write_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NB-1:0] wr_be = '0;
  logic [DW-1:0] top_data_in = '0;
  logic          read_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] dout0, dout1;
  logic          v0, v1, c0, c1, rdy0, rdy1;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state
  logic [DW-1:0] mMem [DEPTH];
  logic          mReady = 1'b0;
  int            mClrCnt = 0;
  logic          p1V = 1'b0, p1C = 1'b0, p2V = 1'b0, p2C = 1'b0;
  logic [DW-1:0] p1Old = '0, p1New = '0, p2Old = '0;
  logic          eV0 = 1'b0, eC0 = 1'b0, eV1 = 1'b0, eC1 = 1'b0;
  logic [DW-1:0] eD0 = '0, eD1 = '0;

  ram_banked_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_BITS(BB), .RDW_MODE(1), .OUT_REG(0)
  ) dut0 (
    .clock(clock), .reset(reset), .write_en(write_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .top_data_in(top_data_in), .read_en(read_en),
    .rd_addr(rd_addr), .top_data_out(dout0), .rd_valid(v0),
    .collision(c0), .ready(rdy0)
  );

  ram_banked_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_BITS(BB), .RDW_MODE(0), .OUT_REG(1)
  ) dut1 (
    .clock(clock), .reset(reset), .write_en(write_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .top_data_in(top_data_in), .read_en(read_en),
    .rd_addr(rd_addr), .top_data_out(dout1), .rd_valid(v1),
    .collision(c1), .ready(rdy1)
  );

  always #5 clock = ~clock;

  // Overall time bound in case the clock or a task stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldW,
                                                 input logic [DW-1:0] newW,
                                                 input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = oldW;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = newW[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rndWord();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] rndAddr();
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Drives one cycle of inputs on the falling edge, then advances the model
  // across the rising edge and leaves time 1 unit after that edge.
  task automatic applyStimulus(input logic rst, input logic we,
                               input logic [AW-1:0] wa, input logic [NB-1:0] be,
                               input logic [DW-1:0] din, input logic re,
                               input logic [AW-1:0] ra);
    logic acc;
    @(negedge clock);
    reset = rst; write_en = we; wr_addr = wa; wr_be = be;
    top_data_in = din; read_en = re; rd_addr = ra;
    @(posedge clock);
    acc = !rst && mReady;
    if (rst) begin
      mReady = 1'b0; mClrCnt = 0;
      p1V = 1'b0; p1C = 1'b0; p2V = 1'b0; p2C = 1'b0;
      eV0 = 1'b0; eC0 = 1'b0; eD0 = '0;
      eV1 = 1'b0; eC1 = 1'b0; eD1 = '0;
    end else begin
      eV0 = p1V; eC0 = p1V && p1C; if (p1V) eD0 = p1New;
      eV1 = p2V; eC1 = p2V && p2C; if (p2V) eD1 = p2Old;
      p2V = p1V; p2C = p1C; p2Old = p1Old;
      p1V   = acc && re;
      p1C   = acc && re && we && (wa == ra);
      p1Old = mMem[ra];
      p1New = p1C ? mergeBytes(mMem[ra], din, be) : mMem[ra];
      if (acc && we) mMem[wa] = mergeBytes(mMem[wa], din, be);
      if (!mReady) begin
        mClrCnt++;
        if (mClrCnt == ROWS) begin
          mReady = 1'b1;
          foreach (mMem[i]) mMem[i] = '0;
        end
      end
    end
    #1;
  endtask

  // Reset, then the full clear with ignored traffic during INIT.
  task automatic test_reset();
    logic we, re;
    for (int s = 0; s < ROWS + 6; s++) begin
      we = 1'b0; re = 1'b0;
      if (!mReady) begin
        we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      end
      applyStimulus(s < 2, we, rndAddr(), '1, rndWord(), re, rndAddr());
      testCount++;
      if ({v0, c0, rdy0, dout0} !== {eV0, eC0, mReady, eD0}) begin
        failCount++;
        $display("[TB] FAIL reset dut0 s=%0d got v=%b c=%b rdy=%b d=%h exp v=%b c=%b rdy=%b d=%h",
                 s, v0, c0, rdy0, dout0, eV0, eC0, mReady, eD0);
      end
      testCount++;
      if ({v1, c1, rdy1, dout1} !== {eV1, eC1, mReady, eD1}) begin
        failCount++;
        $display("[TB] FAIL reset dut1 s=%0d got v=%b c=%b rdy=%b d=%h exp v=%b c=%b rdy=%b d=%h",
                 s, v1, c1, rdy1, dout1, eV1, eC1, mReady, eD1);
      end
    end
  endtask

  // Garbage writes, reset, clear, then every address must read back zero.
  task automatic test_clear();
    logic rst, we, re;
    logic [AW-1:0] ra;
    int total;
    total = 40 + 1 + ROWS + 2 + DEPTH + 3;
    for (int s = 0; s < total; s++) begin
      rst = (s == 40);
      we  = (s < 40);
      re  = (s >= 40 + 1 + ROWS + 2) && (s < 40 + 1 + ROWS + 2 + DEPTH);
      ra  = AW'(s - (40 + 1 + ROWS + 2));
      applyStimulus(rst, we, rndAddr(), '1, rndWord(), re, ra);
      testCount++;
      if ({v0, c0, rdy0, dout0} !== {eV0, eC0, mReady, eD0}) begin
        failCount++;
        $display("[TB] FAIL clear dut0 s=%0d got v=%b c=%b rdy=%b d=%h exp v=%b c=%b rdy=%b d=%h",
                 s, v0, c0, rdy0, dout0, eV0, eC0, mReady, eD0);
      end
      testCount++;
      if ({v1, c1, rdy1, dout1} !== {eV1, eC1, mReady, eD1}) begin
        failCount++;
        $display("[TB] FAIL clear dut1 s=%0d got v=%b c=%b rdy=%b d=%h exp v=%b c=%b rdy=%b d=%h",
                 s, v1, c1, rdy1, dout1, eV1, eC1, mReady, eD1);
      end
    end
  endtask

  // Same row in different banks must not disturb one another.
  task automatic test_bank_walk();
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] words [3];
    logic we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] din;
    addrs[0] = 12'h000; addrs[1] = 12'h400; addrs[2] = 12'hC00; addrs[3] = 12'h800;
    words[0] = {16{8'hA5}}; words[1] = {16{8'h5A}};
    words[2] = 128'h0123456789ABCDEF0123456789ABCDEF;
    for (int s = 0; s < 15; s++) begin
      we = (s < 3); wa = addrs[s % 3]; din = words[s % 3];
      re = (s >= 3) && (((s - 3) % 3) == 0);
      ra = addrs[((s - 3) / 3) % 4];
      applyStimulus(1'b0, we, wa, '1, din, re, ra);
      testCount++;
      if ({v0, c0, dout0} !== {eV0, eC0, eD0}) begin
        failCount++;
        $display("[TB] FAIL bank_walk dut0 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v0, c0, dout0, eV0, eC0, eD0);
      end
      testCount++;
      if ({v1, c1, dout1} !== {eV1, eC1, eD1}) begin
        failCount++;
        $display("[TB] FAIL bank_walk dut1 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v1, c1, dout1, eV1, eC1, eD1);
      end
    end
  endtask

  // Partial byte write and a zero-enable write that must change nothing.
  task automatic test_byte_enable();
    logic we, re;
    logic [NB-1:0] be;
    logic [DW-1:0] din;
    for (int s = 0; s < 7; s++) begin
      we = (s == 0) || (s == 1) || (s == 3);
      re = (s == 2) || (s == 4);
      be = (s == 0) ? '1 : ((s == 1) ? 16'h00FF : '0);
      din = (s == 0) ? '1 : ((s == 1) ? '0 : rndWord());
      applyStimulus(1'b0, we, 12'h7FF, be, din, re, 12'h7FF);
      testCount++;
      if ({v0, c0, dout0} !== {eV0, eC0, eD0}) begin
        failCount++;
        $display("[TB] FAIL byte_enable dut0 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v0, c0, dout0, eV0, eC0, eD0);
      end
      testCount++;
      if ({v1, c1, dout1} !== {eV1, eC1, eD1}) begin
        failCount++;
        $display("[TB] FAIL byte_enable dut1 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v1, c1, dout1, eV1, eC1, eD1);
      end
    end
  endtask

  // Same-address read during write, full-word and partial-byte.
  task automatic test_collision();
    logic we, re;
    logic [AW-1:0] a;
    logic [NB-1:0] be;
    logic [DW-1:0] din;
    for (int s = 0; s < 10; s++) begin
      a  = (s < 5) ? 12'h010 : 12'h020;
      we = (s == 0) || (s == 2) || (s == 5) || (s == 6);
      re = (s == 2) || (s == 3) || (s == 6);
      be = (s == 6) ? NB'($urandom()) : '1;
      din = (s == 0) ? 128'h1111 : ((s == 2) ? 128'h2222 : rndWord());
      applyStimulus(1'b0, we, a, be, din, re, a);
      testCount++;
      if ({v0, c0, dout0} !== {eV0, eC0, eD0}) begin
        failCount++;
        $display("[TB] FAIL collision dut0 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v0, c0, dout0, eV0, eC0, eD0);
      end
      testCount++;
      if ({v1, c1, dout1} !== {eV1, eC1, eD1}) begin
        failCount++;
        $display("[TB] FAIL collision dut1 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v1, c1, dout1, eV1, eC1, eD1);
      end
    end
  endtask

  // Four back-to-back reads, then a read right after a write.
  task automatic test_back_to_back();
    logic we, re;
    logic [AW-1:0] wa, ra;
    for (int s = 0; s < 13; s++) begin
      we = (s < 4) || (s == 8);
      wa = (s < 4) ? AW'(s + 1) : 12'h005;
      re = ((s >= 4) && (s < 8)) || (s == 9);
      ra = (s < 8) ? AW'(s - 3) : 12'h005;
      applyStimulus(1'b0, we, wa, '1, rndWord(), re, ra);
      testCount++;
      if ({v0, c0, dout0} !== {eV0, eC0, eD0}) begin
        failCount++;
        $display("[TB] FAIL back_to_back dut0 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v0, c0, dout0, eV0, eC0, eD0);
      end
      testCount++;
      if ({v1, c1, dout1} !== {eV1, eC1, eD1}) begin
        failCount++;
        $display("[TB] FAIL back_to_back dut1 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v1, c1, dout1, eV1, eC1, eD1);
      end
    end
  endtask

  // Random traffic over a small address pool so collisions are frequent.
  task automatic test_random();
    logic [AW-1:0] pool [6];
    logic [AW-1:0] wa, ra;
    logic [NB-1:0] be;
    foreach (pool[i]) pool[i] = rndAddr();
    for (int s = 0; s < 400; s++) begin
      wa = ($urandom_range(0, 3) == 0) ? rndAddr() : pool[$urandom_range(0, 5)];
      ra = ($urandom_range(0, 3) == 0) ? rndAddr() : pool[$urandom_range(0, 5)];
      be = ($urandom_range(0, 1) == 0) ? '1 : NB'($urandom());
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), wa, be, rndWord(),
                    1'($urandom_range(0, 1)), ra);
      testCount++;
      if ({v0, c0, dout0} !== {eV0, eC0, eD0}) begin
        failCount++;
        $display("[TB] FAIL random dut0 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v0, c0, dout0, eV0, eC0, eD0);
      end
      testCount++;
      if ({v1, c1, dout1} !== {eV1, eC1, eD1}) begin
        failCount++;
        $display("[TB] FAIL random dut1 s=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                 s, v1, c1, dout1, eV1, eC1, eD1);
      end
    end
  endtask

  // Reset with a read in flight, then reset again mid-clear at count 5.
  task automatic test_mid_reset();
    logic rst, we, re;
    int total;
    total = 9 + ROWS + 2 + 4;
    for (int s = 0; s < total; s++) begin
      rst = (s == 2) || (s == 8);
      we  = (s == 0);
      re  = (s == 1) || (s == 2) || (s == total - 4) ||
            ((s > 2) && (s < total - 4) && ($urandom_range(0, 1) == 1));
      applyStimulus(rst, we, 12'h123, '1, rndWord(), re, 12'h123);
      testCount++;
      if ({v0, c0, rdy0, dout0} !== {eV0, eC0, mReady, eD0}) begin
        failCount++;
        $display("[TB] FAIL mid_reset dut0 s=%0d got v=%b c=%b rdy=%b d=%h exp v=%b c=%b rdy=%b d=%h",
                 s, v0, c0, rdy0, dout0, eV0, eC0, mReady, eD0);
      end
      testCount++;
      if ({v1, c1, rdy1, dout1} !== {eV1, eC1, mReady, eD1}) begin
        failCount++;
        $display("[TB] FAIL mid_reset dut1 s=%0d got v=%b c=%b rdy=%b d=%h exp v=%b c=%b rdy=%b d=%h",
                 s, v1, c1, rdy1, dout1, eV1, eC1, mReady, eD1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_bank_walk();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ram_banked_dp.md
# ram_banked_dp

Parametrised, banked, synchronous dual-port RAM. It has one write port and one read port, and is the generalised successor of the fixed 4Kx128 dual-port RAM top. Storage is split into 2^BANK_BITS banks, selected by the upper address bits. It adds:
- per-byte write enables
- a registered read-data mux, so there are no shared output drivers
- a defined read-during-write policy with a collision flag
- an optional output pipeline register
- a hardware clear sequence after reset

It sits between the datapath and any client that needs deterministic, zero-initialised buffer memory.

## Interface
- DATA_WIDTH, 128, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, word address width; depth = 2^ADDR_WIDTH.
- BANK_BITS, 2, number of bank-select bits (upper address bits); banks = 2^BANK_BITS; 1 ≤ BANK_BITS < ADDR_WIDTH.
- RDW_MODE, 1, same-address read-during-write behaviour: 0 = old data, 1 = new data (write-first).
- OUT_REG, 0, 1 adds one output pipeline stage.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  write request; qualified by ready.
- wr_addr  in  ADDR_WIDTH  write word address; [ADDR_WIDTH-1 -: BANK_BITS] selects the bank.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers top_data_in[8i+7:8i].
- top_data_in  in  DATA_WIDTH  write data.
- read_en  in  1  read request; qualified by ready.
- rd_addr  in  ADDR_WIDTH  read word address.
- top_data_out  out  DATA_WIDTH  read data; held between reads.
- rd_valid  out  1  one-cycle pulse marking top_data_out as new.
- collision  out  1  pulses with rd_valid when the read hit the same address as a concurrent write.
- ready  out  1  high when the clear sequence is done and requests are accepted.

## Operation
- States: INIT and RUN.
- Reset, in any state and at any point including mid-INIT:
  - State goes to INIT and the clear counter goes to 0.
  - ready, rd_valid, collision and top_data_out are all 0.
  - The read pipeline is flushed.
- INIT:
  - Each cycle, row `cnt` (the bank-local address, ROWS = 2^(ADDR_WIDTH-BANK_BITS)) is written with 0 in every bank simultaneously, and cnt increments.
  - After row ROWS-1 is written, the state goes to RUN.
  - write_en and read_en are ignored and produce no rd_valid.
- RUN, write: when write_en is high, every enabled byte of the addressed word is updated at the clock edge. wr_be = 0 is a no-op.
- RUN, read: when read_en is high, the addressed word is fetched.
  - The bank index is registered alongside the fetch, and the output mux selects using that registered index.
  - Only the selected bank drives top_data_out.
- Concurrent read and write to different addresses or banks are independent.
- Concurrent read and write to the same address (read_en & write_en & rd_addr == wr_addr):
  - collision = 1, aligned with that read's rd_valid.
  - RDW_MODE=0: the returned data is the pre-write word.
  - RDW_MODE=1: enabled bytes return top_data_in and disabled bytes return the old contents. The bypass merge is per byte.
- A read issued on the cycle after a write to the same address always returns the written data.
- With no read_en, top_data_out holds its last value and rd_valid = 0.
- Address wrap-around does not exist; every address is in range by construction.

## Timing
- Clear sequence: ready rises on the first clock edge after reset deasserts plus ROWS cycles. With the defaults (ROWS = 1024), ready = 1 in the 1025th cycle after the reset cycle.
- Read latency: read_en sampled at edge N gives rd_valid/top_data_out valid after edge N+1 when OUT_REG=0, or after N+2 when OUT_REG=1.
- The read port is fully pipelined: back-to-back reads give back-to-back rd_valid pulses.
- A write takes effect at the sampling edge.
- No backpressure: ready never falls in RUN except through reset.
- Reset asserted while a read is in flight: that rd_valid never appears.

## Test plan
- Reset and clear (ADDR_WIDTH=6, BANK_BITS=2, ROWS=16):
  - Pre-write garbage in RUN, then pulse reset.
  - ready must stay 0 for 16 cycles after reset deasserts.
  - After ready, reading all 64 addresses returns 0.
- Bank walk (default parameters):
  - Write addr 0x000 = 128'hA5..A5, addr 0x400 = 128'h5A..5A, addr 0xC00 = 128'h0123..CDEF.
  - Reading each address gives its exact word, rd_valid at latency 1, and no cross-bank corruption.
- Byte enables:
  - Write 0x7FF with all ones, then write 0x7FF with data 0 and wr_be = 16'h00FF.
  - The read returns 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000.
- Collision:
  - Address 0x010 holds 128'h1111; in one cycle, write 128'h2222 (all bytes) and read 0x010.
  - RDW_MODE=1 returns 128'h2222 with collision = 1; RDW_MODE=0 returns 128'h1111 with collision = 1.
  - The next read returns 128'h2222 with collision = 0.
- Pipelining, OUT_REG=1: four back-to-back reads of 0x001..0x004 give rd_valid high on 4 consecutive cycles, starting 2 cycles after the first read_en, with data in order.
- Mid-operation reset:
  - Assert reset mid-INIT (cnt = 5) and also with a read in flight.
  - No rd_valid emerges, and the counter restarts at 0 with the full ROWS-cycle clear.
